// File: rtl/bcd_to_bin.sv
// Purpose : sequential packed-BCD to binary converter, one digit per clock, MSD first (acc = acc*10 + digit).
// Latency : DIGITS clocks from the start-sampling edge to the edge that raises done; one conversion per DIGITS+1 clocks.
// Backpr. : start is accepted only in IDLE (including the done cycle); start while busy is dropped, never queued.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous active-high reset; aborts any conversion without a done pulse
//   start   - conversion request, sampled only when idle
//   bcd_in  - packed BCD input, bits [4*DIGITS-1 -: 4] are the most-significant digit
//   busy    - high while a conversion is in progress
//   done    - one-cycle pulse; bin/err/ovf valid from this cycle on
//   bin     - binary result (0 on digit error, all ones on overflow), held until the next done
//   err     - at least one digit was > 9
//   ovf     - decimal value >= 2^W (masked by err)
module bcd_to_bin #(
    parameter int DIGITS = 6,
    parameter int W      = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [W-1:0]          bin,
    output logic                  err,
    output logic                  ovf
);

    localparam int WX = W + 4;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [4*DIGITS-1:0] sreg;
    logic [W-1:0]        acc;
    logic [CW-1:0]       cnt;
    logic                e;
    logic                o;

    logic [3:0]          d;
    logic [WX-1:0]       acc_next;
    logic                ovf_now;
    logic [W-1:0]        acc_sat;
    logic                e_nxt;
    logic                o_nxt;
    logic                last;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Next-state and per-digit arithmetic
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        d         = sreg[4*DIGITS-1 -: 4];
        // acc < 2^W is kept invariant, so acc*10 + 15 fits in W+4 bits.
        acc_next  = {4'b0000, acc} * WX'(10) + WX'(d);
        ovf_now   = |acc_next[WX-1:W];
        // Saturate: once clamped to 2^W-1, every later digit overflows again.
        acc_sat   = ovf_now ? {W{1'b1}} : acc_next[W-1:0];
        e_nxt     = e | (d > 4'd9);
        o_nxt     = o | ovf_now;
        last      = (cnt == CW'(DIGITS - 1));

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == CONV);

    // ---------------------------------------------------------------
    // Datapath and result registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            acc  <= '0;
            cnt  <= '0;
            e    <= 1'b0;
            o    <= 1'b0;
            done <= 1'b0;
            bin  <= '0;
            err  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg <= bcd_in;
                        acc  <= '0;
                        cnt  <= '0;
                        e    <= 1'b0;
                        o    <= 1'b0;
                    end
                end
                CONV: begin
                    sreg <= sreg << 4;
                    acc  <= acc_sat;
                    cnt  <= cnt + CW'(1);
                    e    <= e_nxt;
                    o    <= o_nxt;
                    if (last) begin
                        done <= 1'b1;
                        err  <= e_nxt;
                        // A bad digit makes the magnitude meaningless, so err wins.
                        ovf  <= o_nxt & ~e_nxt;
                        bin  <= e_nxt ? '0 : acc_sat;
                    end
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Purpose : directed self-checking bench for bcd_to_bin (DIGITS=6, W=18).
// Latency : expects done exactly 6 clocks after the start-sampling edge.
// Backpr. : exercises start-while-busy, start-in-done-cycle and reset abort.
module tb_bcd_to_bin;

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] bcd_in;
    logic        busy;
    logic        done;
    logic [17:0] bin;
    logic        err;
    logic        ovf;

    int n_chk;
    int n_fail;

    bcd_to_bin #(
        .DIGITS (6),
        .W      (18)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .bin    (bin),
        .err    (err),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called right after the start-sampling edge. Returns cycles until done and busy cycles seen.
    task automatic wait_done(input string tag, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic run_conv(input string tag, input logic [23:0] bcd,
                            input logic [17:0] eb, input logic ee, input logic eo);
        int lat;
        int bcnt;
        start  = 1'b1;
        bcd_in = bcd;
        step();
        start  = 1'b0;
        bcd_in = 24'hABCDEF;
        wait_done(tag, lat, bcnt);
        check({tag, "_lat"}, 32'(lat), 32'd6);
        check({tag, "_bin"}, 32'(bin), 32'(eb));
        check({tag, "_err"}, 32'(err), 32'(ee));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    initial begin
        int lat;
        int bcnt;
        int ndone;
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = 24'h0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bin",  32'(bin),  32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        reset = 1'b0;
        step();

        // Zero input: latency, busy width, one-cycle done.
        start  = 1'b1;
        bcd_in = 24'h000000;
        step();
        start  = 1'b0;
        check("zero_busy_rise", 32'(busy), 32'd1);
        wait_done("zero", lat, bcnt);
        check("zero_lat",       32'(lat),  32'd6);
        check("zero_busycnt",   32'(bcnt), 32'd6);
        check("zero_busy_done", 32'(busy), 32'd0);
        check("zero_bin",       32'(bin),  32'd0);
        check("zero_err",       32'(err),  32'd0);
        check("zero_ovf",       32'(ovf),  32'd0);
        step();
        check("zero_done_pulse", 32'(done), 32'd0);

        // Main function and boundary values.
        run_conv("v123456", 24'h123456, 18'h1E240, 1'b0, 1'b0);
        step();
        step();
        check("hold_bin", 32'(bin), 32'h1E240);
        run_conv("v262143", 24'h262143, 18'h3FFFF, 1'b0, 1'b0);
        run_conv("v262144", 24'h262144, 18'h3FFFF, 1'b0, 1'b1);
        run_conv("v999999", 24'h999999, 18'h3FFFF, 1'b0, 1'b1);
        run_conv("v12A456", 24'h12A456, 18'h00000, 1'b1, 1'b0);
        run_conv("vF99999", 24'hF99999, 18'h00000, 1'b1, 1'b0);
        step();

        // Handshake: stray start while busy is ignored, bcd_in may change after start.
        start  = 1'b1;
        bcd_in = 24'h000042;
        step();
        start  = 1'b0;
        bcd_in = 24'h777777;
        step();
        step();
        start  = 1'b1;
        bcd_in = 24'h000099;
        step();
        start  = 1'b0;
        bcd_in = 24'h000123;
        lat    = 3;
        ndone  = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        check("hs_done_seen", 32'(done), 32'd1);
        check("hs_lat", 32'(lat), 32'd6);
        check("hs_bin", 32'(bin), 32'd42);
        check("hs_err", 32'(err), 32'd0);
        // Back-to-back: start in the done cycle.
        run_conv("b2b", 24'h000007, 18'd7, 1'b0, 1'b0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) ndone++;
        end
        check("b2b_no_extra_done", 32'(ndone), 32'd0);

        // Reset mid-operation aborts without done.
        start  = 1'b1;
        bcd_in = 24'h555555;
        step();
        start  = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_bin",  32'(bin),  32'd0);
        check("rmid_done", 32'(done), 32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) ndone++;
        end
        check("rmid_no_done", 32'(ndone), 32'd0);
        run_conv("after_rst", 24'h000010, 18'd10, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
